bus_mailbox: RTL and testbench
==============================

// Module: bus_mailbox
// PURPOSE
//  Memory-mapped device (responder) on the simple-system device bus, paired with the core's data host port.
//  Software writes words into a TX FIFO and reads words from an RX FIFO.
//  External agents (testbench, companion core) drain TX and fill RX over valid/ready streams.
//  Sits on the bus beside ram/simulator_ctrl/timer; offsets are relative to the bus address window.
// PARAMETERS
//  DataWidth     32  bus data width; must be 32
//  AddressWidth  32  bus address width; only addr_i[9:2] decoded (1 kB window)
//  Depth         8   entries per FIFO; power of 2, 2..128
// PORTS
//  clk_i       in   1   clock
//  rst_i       in   1   synchronous reset, active-high
//  req_i       in   1   device request (always accepted, bus owns gnt)
//  we_i        in   1   1=write 0=read
//  be_i        in   4   byte enables
//  addr_i      in   AW  byte address
//  wdata_i     in   32  write data
//  rvalid_o    out  1   response valid, exactly 1 cycle after req_i
//  rdata_o     out  32  read data, qualified by rvalid_o
//  err_o       out  1   error response, qualified by rvalid_o
//  tx_valid_o  out  1   TX FIFO head valid
//  tx_ready_i  in   1   external pop of TX head
//  tx_data_o   out  32  TX FIFO head word
//  rx_valid_i  in   1   external push into RX
//  rx_ready_o  out  1   RX FIFO not full
//  rx_data_i   in   32  RX push word
//  irq_o       out  1   level interrupt (see CONFIGURATION)
// BEHAVIOUR
//  Reset: FIFOs empty, rvalid_o/err_o/irq_o=0, rdata_o=0, tx_valid_o=0, rx_ready_o=1, IRQ_EN=0.
//  Map (addr_i[9:2]): 0x00 TXDATA W; 0x04 RXDATA R; 0x08 STATUS R; 0x0C IRQ_EN RW (macro only).
//  Every req_i gets rvalid_o=1 next cycle; back-to-back requests give back-to-back responses.
//  TXDATA write: push iff be_i==4'hF and TX not full; else err_o=1, no push. Read of TXDATA -> err.
//  RXDATA read: pop head; rdata_o=head. If empty: rdata_o=0, err_o=1. Write to RXDATA -> err.
//  STATUS: [31]=tx_full [30]=rx_empty [23:16]=rx_level [7:0]=tx_level; other bits 0. Write -> err.
//  Unmapped offset -> err_o=1, rdata_o=0, no side effects.
//  Fullness/emptiness is sampled at the start of the request cycle.
//    Simultaneous tx pop on a full TX does not make room: the bus push errors.
//    Simultaneous rx push on an empty RX does not satisfy the bus pop: it errors.
//  Stream handshakes: transfer when valid&ready on a rising edge; tx_data_o stable while tx_valid_o & !tx_ready_i.
//  Level counters width $clog2(Depth+1); push+pop same cycle on a non-full/non-empty FIFO keeps the level.
//    Pointers wrap modulo Depth.
//  rst_i mid-transaction: pending response dropped (rvalid_o=0 next cycle), FIFO contents discarded.
// CONFIGURATION
//  BUS_MAILBOX_IRQ_EN defined:
//    IRQ_EN register: [0]=rx_nonempty enable, [1]=tx_empty enable; other write bits ignored.
//    irq_o registered = (en[0]&!rx_empty)|(en[1]&tx_empty), asserted the cycle after the condition.
//  Not defined: irq_o tied 0; offset 0x0C is unmapped (err).
// STRUCTURE
//  bus_mailbox_pkg: register offset localparams, STATUS bit positions, status_t packed struct.
//  Sub-module bus_mailbox_fifo #(Width, Depth): sync FIFO with push/pop/full/empty/level; instantiated twice.
// TESTING
//  Reset, read STATUS @0x08 -> rdata 0x4000_0000, err 0, rvalid exactly 1 cycle after req.
//  Write 0xDEADBEEF,0x1234 to 0x00 with tx_ready_i=0 -> tx_valid_o=1, tx_data_o=0xDEADBEEF,
//    tx_level=2; pulse tx_ready_i -> tx_data_o=0x1234.
//  Fill TX with Depth=8 writes, 9th write -> err_o=1, level stays 8.
//    Same with tx_ready_i=1 in the 9th request cycle -> still err, level 7 after.
//  Write be_i=4'h3 to 0x00 -> err_o=1, tx_level unchanged; read 0x10 -> err_o=1, rdata 0.
//  Push 0xA5A5A5A5 on rx stream, read 0x04 -> rdata 0xA5A5A5A5, err 0.
//    Second read -> rdata 0, err 1; rx_ready_o=0 after 8 pushes.
//  With BUS_MAILBOX_IRQ_EN: write 0x1 to 0x0C, push RX word -> irq_o=1 next cycle; read 0x04 -> irq_o=0.
//    Assert rst_i while irq_o=1 -> irq_o=0 and FIFOs empty after one edge.

Source files
------------

// File: rtl/bus_mailbox_pkg.sv
// Shared register map, STATUS layout and status packing helper for bus_mailbox.
// Offsets are word indices into addr_i[9:2].
package bus_mailbox_pkg;

  localparam logic [7:0] OFF_TXDATA = 8'h00;
  localparam logic [7:0] OFF_RXDATA = 8'h01;
  localparam logic [7:0] OFF_STATUS = 8'h02;
  localparam logic [7:0] OFF_IRQ_EN = 8'h03;

  localparam int STATUS_TX_FULL_BIT  = 31;
  localparam int STATUS_RX_EMPTY_BIT = 30;
  localparam int STATUS_RX_LEVEL_LSB = 16;
  localparam int STATUS_TX_LEVEL_LSB = 0;

  typedef struct packed {
    logic       tx_full;
    logic       rx_empty;
    logic [5:0] rsvd_hi;
    logic [7:0] rx_level;
    logic [7:0] rsvd_lo;
    logic [7:0] tx_level;
  } status_t;

  function automatic status_t pack_status(input logic       tx_full,
                                          input logic       rx_empty,
                                          input logic [7:0] rx_level,
                                          input logic [7:0] tx_level);
    status_t s;
    s          = '0;
    s.tx_full  = tx_full;
    s.rx_empty = rx_empty;
    s.rx_level = rx_level;
    s.tx_level = tx_level;
    return s;
  endfunction

endpackage

// File: rtl/bus_mailbox_fifo.sv
// Synchronous FIFO, combinational head read; push ignored when full, pop ignored when empty.
// Push and pop in the same cycle keep the level; pointers wrap modulo Depth (power of 2).
module bus_mailbox_fifo #(
  parameter int Width = 32,
  parameter int Depth = 8
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_push,
  input  logic [Width-1:0]               i_data,
  input  logic                           i_pop,
  output logic [Width-1:0]               o_data,
  output logic                           o_full,
  output logic                           o_empty,
  output logic [$clog2(Depth+1)-1:0]     o_level
);

  localparam int PW = $clog2(Depth);
  localparam int LW = $clog2(Depth + 1);

  logic [Width-1:0] r_mem [Depth];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_level == LW'(Depth));
  assign o_empty = (r_level == '0);
  assign o_level = r_level;
  assign o_data  = r_mem[r_rd_ptr];
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  // Storage is not reset: contents are unreachable once the pointers clear.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/bus_mailbox.sv
// Bus mailbox: TX/RX word FIFOs behind a 1 kB device window; responses exactly one cycle after req_i.
// Optional IRQ_EN register and level interrupt when BUS_MAILBOX_IRQ_EN is defined.
module bus_mailbox
  import bus_mailbox_pkg::*;
#(
  parameter int DataWidth    = 32,
  parameter int AddressWidth = 32,
  parameter int Depth        = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_i,
  input  logic                    we_i,
  input  logic [3:0]              be_i,
  input  logic [AddressWidth-1:0] addr_i,
  input  logic [DataWidth-1:0]    wdata_i,
  output logic                    rvalid_o,
  output logic [DataWidth-1:0]    rdata_o,
  output logic                    err_o,
  output logic                    tx_valid_o,
  input  logic                    tx_ready_i,
  output logic [DataWidth-1:0]    tx_data_o,
  input  logic                    rx_valid_i,
  output logic                    rx_ready_o,
  input  logic [DataWidth-1:0]    rx_data_i,
  output logic                    irq_o
);

  localparam int LW = $clog2(Depth + 1);

  logic [7:0]           w_off;
  logic                 w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
  logic [LW-1:0]        w_tx_level, w_rx_level;
  logic [DataWidth-1:0] w_rx_head;
  logic                 w_tx_push, w_tx_pop, w_rx_push, w_rx_pop;
  logic                 w_resp_err;
  logic [DataWidth-1:0] w_resp_dat;
  status_t              w_status;
  logic                 r_rvalid;
  logic                 r_err;
  logic [DataWidth-1:0] r_rdata;
  logic                 w_unused;

  assign w_off      = addr_i[9:2];
  assign w_unused   = ^{addr_i[AddressWidth-1:10], addr_i[1:0]};
  assign tx_valid_o = ~w_tx_empty;
  assign rx_ready_o = ~w_rx_full;
  assign w_tx_pop   = tx_ready_i & ~w_tx_empty;
  assign w_rx_push  = rx_valid_i & ~w_rx_full;
  assign w_status   = pack_status(w_tx_full, w_rx_empty, 8'(w_rx_level), 8'(w_tx_level));

  bus_mailbox_fifo #(.Width(DataWidth), .Depth(Depth)) u_tx_fifo (
    .i_clk   (clk_i),
    .i_rst   (rst_i),
    .i_push  (w_tx_push),
    .i_data  (wdata_i),
    .i_pop   (w_tx_pop),
    .o_data  (tx_data_o),
    .o_full  (w_tx_full),
    .o_empty (w_tx_empty),
    .o_level (w_tx_level)
  );

  bus_mailbox_fifo #(.Width(DataWidth), .Depth(Depth)) u_rx_fifo (
    .i_clk   (clk_i),
    .i_rst   (rst_i),
    .i_push  (w_rx_push),
    .i_data  (rx_data_i),
    .i_pop   (w_rx_pop),
    .o_data  (w_rx_head),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty),
    .o_level (w_rx_level)
  );

`ifdef BUS_MAILBOX_IRQ_EN
  logic       w_irq_en_we;
  logic [1:0] r_irq_en;
  logic       r_irq;
`endif

  // Full/empty flags are pre-edge values, so a same-cycle stream transfer never rescues a bus access.
  always_comb begin
    w_tx_push  = 1'b0;
    w_rx_pop   = 1'b0;
    w_resp_err = 1'b0;
    w_resp_dat = '0;
`ifdef BUS_MAILBOX_IRQ_EN
    w_irq_en_we = 1'b0;
`endif
    if (req_i) begin
      case (w_off)
        OFF_TXDATA: begin
          if (we_i && be_i == 4'hF && !w_tx_full) w_tx_push  = 1'b1;
          else                                    w_resp_err = 1'b1;
        end
        OFF_RXDATA: begin
          if (!we_i && !w_rx_empty) begin
            w_rx_pop   = 1'b1;
            w_resp_dat = w_rx_head;
          end else begin
            w_resp_err = 1'b1;
          end
        end
        OFF_STATUS: begin
          if (!we_i) w_resp_dat = w_status;
          else       w_resp_err = 1'b1;
        end
`ifdef BUS_MAILBOX_IRQ_EN
        OFF_IRQ_EN: begin
          if (we_i) w_irq_en_we = 1'b1;
          else      w_resp_dat  = {{(DataWidth-2){1'b0}}, r_irq_en};
        end
`endif
        default: w_resp_err = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= req_i;
      r_err    <= w_resp_err;
      r_rdata  <= w_resp_dat;
    end
  end

  assign rvalid_o = r_rvalid;
  assign err_o    = r_err;
  assign rdata_o  = r_rdata;

`ifdef BUS_MAILBOX_IRQ_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_irq_en <= 2'b00;
      r_irq    <= 1'b0;
    end else begin
      if (w_irq_en_we) r_irq_en <= wdata_i[1:0];
      r_irq <= (r_irq_en[0] & ~w_rx_empty) | (r_irq_en[1] & w_tx_empty);
    end
  end
  assign irq_o = r_irq;
`else
  assign irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_bus_mailbox.sv
// Directed bench for bus_mailbox (Depth=8); IRQ section follows BUS_MAILBOX_IRQ_EN.
module tb_bus_mailbox;

  logic        clk_i = 1'b0;
  logic        rst_i, req_i, we_i;
  logic [3:0]  be_i;
  logic [31:0] addr_i, wdata_i;
  logic        rvalid_o, err_o;
  logic [31:0] rdata_o;
  logic        tx_valid_o, tx_ready_i;
  logic [31:0] tx_data_o;
  logic        rx_valid_i, rx_ready_o;
  logic [31:0] rx_data_i;
  logic        irq_o;

  int n_checks = 0;
  int n_fail   = 0;

  bus_mailbox dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .be_i(be_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
    .err_o(err_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
    .tx_data_o(tx_data_o), .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o),
    .rx_data_i(rx_data_i), .irq_o(irq_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic bus_chk(input string tag, input logic we, input logic [31:0] addr,
                         input logic [3:0] be, input logic [31:0] wd,
                         input logic exp_err, input logic [31:0] exp_rd);
    req_i = 1'b1; we_i = we; addr_i = addr; be_i = be; wdata_i = wd;
    tick();
    req_i = 1'b0; we_i = 1'b0; be_i = 4'h0; wdata_i = '0;
    chk({tag, "_rvalid"}, {31'b0, rvalid_o}, 32'd1);
    chk({tag, "_err"}, {31'b0, err_o}, {31'b0, exp_err});
    if (!we) chk({tag, "_rdata"}, rdata_o, exp_rd);
  endtask

  task automatic status_chk(input string tag, input logic [31:0] exp);
    bus_chk(tag, 1'b0, 32'h08, 4'hF, '0, 1'b0, exp);
  endtask

  task automatic rx_push(input logic [31:0] d);
    rx_valid_i = 1'b1; rx_data_i = d;
    tick();
    rx_valid_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1; req_i = 1'b0; we_i = 1'b0; be_i = 4'h0; addr_i = '0; wdata_i = '0;
    tx_ready_i = 1'b0; rx_valid_i = 1'b0; rx_data_i = '0;
    tick(); tick();
    rst_i = 1'b0;

    chk("rst_rvalid", {31'b0, rvalid_o}, 32'd0);
    chk("rst_err", {31'b0, err_o}, 32'd0);
    chk("rst_rdata", rdata_o, 32'd0);
    chk("rst_irq", {31'b0, irq_o}, 32'd0);
    chk("rst_tx_valid", {31'b0, tx_valid_o}, 32'd0);
    chk("rst_rx_ready", {31'b0, rx_ready_o}, 32'd1);

    // STATUS after reset; response lasts exactly one cycle.
    status_chk("st0", 32'h4000_0000);
    tick();
    chk("rvalid_drop", {31'b0, rvalid_o}, 32'd0);

    bus_chk("tx_w0", 1'b1, 32'h00, 4'hF, 32'hDEAD_BEEF, 1'b0, '0);
    bus_chk("tx_w1", 1'b1, 32'h00, 4'hF, 32'h0000_1234, 1'b0, '0);
    chk("tx_valid", {31'b0, tx_valid_o}, 32'd1);
    chk("tx_head0", tx_data_o, 32'hDEAD_BEEF);
    status_chk("st_tx2", 32'h4000_0002);
    chk("tx_hold", tx_data_o, 32'hDEAD_BEEF);
    tx_ready_i = 1'b1; tick(); tx_ready_i = 1'b0;
    chk("tx_head1", tx_data_o, 32'h0000_1234);
    tx_ready_i = 1'b1; tick(); tx_ready_i = 1'b0;
    chk("tx_drained", {31'b0, tx_valid_o}, 32'd0);

    for (int i = 0; i < 8; i++) bus_chk("tx_fill", 1'b1, 32'h00, 4'hF, 32'h100 + i, 1'b0, '0);
    status_chk("st_full", 32'hC000_0008);
    bus_chk("tx_ovf", 1'b1, 32'h00, 4'hF, 32'h999, 1'b1, '0);
    status_chk("st_full2", 32'hC000_0008);
    chk("tx_head_full", tx_data_o, 32'h100);
    tx_ready_i = 1'b1;
    bus_chk("tx_ovf_pop", 1'b1, 32'h00, 4'hF, 32'h999, 1'b1, '0);
    tx_ready_i = 1'b0;
    status_chk("st_tx7", 32'h4000_0007);
    chk("tx_head_pop", tx_data_o, 32'h101);
    tx_ready_i = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    tx_ready_i = 1'b0;
    chk("tx_empty", {31'b0, tx_valid_o}, 32'd0);

    bus_chk("tx_be", 1'b1, 32'h00, 4'h3, 32'h55, 1'b1, '0);
    status_chk("st_be", 32'h4000_0000);
    bus_chk("unmapped", 1'b0, 32'h10, 4'hF, '0, 1'b1, 32'h0);
    bus_chk("rd_txdata", 1'b0, 32'h00, 4'hF, '0, 1'b1, 32'h0);
    bus_chk("wr_status", 1'b1, 32'h08, 4'hF, 32'hFFFF_FFFF, 1'b1, '0);
    bus_chk("wr_rxdata", 1'b1, 32'h04, 4'hF, 32'h1, 1'b1, '0);
    status_chk("st_noside", 32'h4000_0000);

    rx_push(32'hA5A5_A5A5);
    status_chk("st_rx1", 32'h0001_0000);
    bus_chk("rx_rd", 1'b0, 32'h04, 4'hF, '0, 1'b0, 32'hA5A5_A5A5);
    bus_chk("rx_rd_empty", 1'b0, 32'h04, 4'hF, '0, 1'b1, 32'h0);
    for (int i = 0; i < 8; i++) rx_push(32'h200 + i);
    chk("rx_full_rdy", {31'b0, rx_ready_o}, 32'd0);
    status_chk("st_rx8", 32'h0008_0000);
    bus_chk("rx_rd_h0", 1'b0, 32'h04, 4'hF, '0, 1'b0, 32'h200);
    chk("rx_rdy_back", {31'b0, rx_ready_o}, 32'd1);
    for (int i = 1; i < 8; i++) bus_chk("rx_rd_h", 1'b0, 32'h04, 4'hF, '0, 1'b0, 32'h200 + i);
    // Push and pop in the same cycle on an empty RX: pop errors, word stays.
    rx_valid_i = 1'b1; rx_data_i = 32'h77;
    bus_chk("rx_race", 1'b0, 32'h04, 4'hF, '0, 1'b1, 32'h0);
    rx_valid_i = 1'b0;
    status_chk("st_race", 32'h4001_0000 & 32'h0FFF_FFFF);
    bus_chk("rx_race_rd", 1'b0, 32'h04, 4'hF, '0, 1'b0, 32'h77);

`ifdef BUS_MAILBOX_IRQ_EN
    bus_chk("irqen_wr", 1'b1, 32'h0C, 4'hF, 32'hFFFF_FFFD, 1'b0, '0);
    bus_chk("irqen_rd", 1'b0, 32'h0C, 4'hF, '0, 1'b0, 32'h1);
    chk("irq_idle", {31'b0, irq_o}, 32'd0);
    rx_push(32'h33);
    chk("irq_pre", {31'b0, irq_o}, 32'd0);
    tick();
    chk("irq_set", {31'b0, irq_o}, 32'd1);
    bus_chk("irq_pop", 1'b0, 32'h04, 4'hF, '0, 1'b0, 32'h33);
    tick();
    chk("irq_clr", {31'b0, irq_o}, 32'd0);
    rx_push(32'h44);
    tick();
    chk("irq_set2", {31'b0, irq_o}, 32'd1);
`else
    bus_chk("irqen_unmapped_w", 1'b1, 32'h0C, 4'hF, 32'h1, 1'b1, '0);
    bus_chk("irqen_unmapped_r", 1'b0, 32'h0C, 4'hF, '0, 1'b1, 32'h0);
    rx_push(32'h44);
    tick();
    chk("irq_tied", {31'b0, irq_o}, 32'd0);
`endif

    // Reset with a request in flight and both FIFOs holding data.
    bus_chk("pre_rst_tx", 1'b1, 32'h00, 4'hF, 32'h5, 1'b0, '0);
    rst_i = 1'b1; req_i = 1'b1; addr_i = 32'h08; we_i = 1'b0;
    tick();
    rst_i = 1'b0; req_i = 1'b0;
    chk("mrst_rvalid", {31'b0, rvalid_o}, 32'd0);
    chk("mrst_irq", {31'b0, irq_o}, 32'd0);
    chk("mrst_tx_valid", {31'b0, tx_valid_o}, 32'd0);
    chk("mrst_rx_ready", {31'b0, rx_ready_o}, 32'd1);
    status_chk("st_mrst", 32'h4000_0000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
